// File: rtl/conv2_pkg.sv
// -----------------------------------------------------------------------------
// conv2_pkg
// Shared types and helpers for the conv_2 convolution engine.
//   state_t    : engine FSM state (IDLE, RUN, DONE)
//   acc_width  : full-precision accumulator width for a given pixel width and
//                kernel side
//   kcoef      : fixed generalised-Laplacian coefficient at kernel position
//                (i,j); the centre is sizeker^2-1 and every other tap is -1
//   sat        : clamp a wide signed value into a signed 'width'-bit range.
//                Only used when CONV2_SATURATE_EN is defined.
// -----------------------------------------------------------------------------
package conv2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int acc_width(input int width, input int sizeker);
        return width + $clog2(sizeker * sizeker) + 1;
    endfunction

    function automatic int kcoef(input int i, input int j, input int sizeker);
        int c;
        c = (sizeker - 1) / 2;
        if ((i == c) && (j == c)) begin
            return sizeker * sizeker - 1;
        end
        return -1;
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] acc,
                                               input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (acc > hi) begin
            return hi;
        end
        if (acc < lo) begin
            return lo;
        end
        return acc;
    endfunction

endpackage

// File: rtl/conv2_window_mac.sv
// -----------------------------------------------------------------------------
// conv2_window_mac
// Combinational multiply-accumulate of one SIZEKer x SIZEKer window against
// the fixed Laplacian kernel (correlation, no kernel flip).
//
// Ports:
//   win    : input window, [i][j], already offset to the current output (r,c)
//   sum    : full-precision signed sum, AW bits
//   result : WIDTH_BIT result; low bits of sum (wrap) by default, or clamped
//            to the signed WIDTH_BIT range when CONV2_SATURATE_EN is defined
// -----------------------------------------------------------------------------
module conv2_window_mac
    import conv2_pkg::*;
#(
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = 16,
    parameter int AW        = acc_width(WIDTH_BIT, SIZEKer)
) (
    input  logic signed [WIDTH_BIT-1:0] win [SIZEKer][SIZEKer],
    output logic signed [AW-1:0]        sum,
    output logic signed [WIDTH_BIT-1:0] result
);

    always_comb begin
        logic signed [AW-1:0] acc;
        logic signed [AW-1:0] px;
        logic signed [AW-1:0] kc;
        // NOTE: blocking assignments here build a combinational adder chain;
        // each iteration must see the value written by the previous one.
        acc = '0;
        for (int i = 0; i < SIZEKer; i++) begin
            for (int j = 0; j < SIZEKer; j++) begin
                px  = AW'(win[i][j]);
                kc  = AW'(kcoef(i, j, SIZEKer));
                acc = acc + px * kc;
            end
        end
        sum = acc;
    end

`ifdef CONV2_SATURATE_EN
    always_comb begin
        result = WIDTH_BIT'(sat(64'(sum), WIDTH_BIT));
    end
`else
    // Two's-complement wrap: keep the low WIDTH_BIT bits.
    always_comb begin
        result = sum[WIDTH_BIT-1:0];
    end
`endif

endmodule

// File: rtl/conv_2.sv
// -----------------------------------------------------------------------------
// conv_2
// Single-channel 2-D "valid" convolution engine with a fixed odd-sized
// Laplacian kernel. One output pixel is computed per clock in row-major order;
// done rises one clock after the last pixel is written and stays high until
// reset.
//
// Parameters:
//   SIZE      : input image side (SIZE >= SIZEKer)
//   SIZEKer   : kernel side (odd, >= 3)
//   WIDTH_BIT : signed pixel / result width
//
// Ports:
//   clock           : rising-edge clock
//   nreset          : synchronous reset, ACTIVE HIGH despite the name
//   inpMatrixI      : input image [row][col], sampled every computing cycle
//   done            : full output map valid (sticky until reset)
//   convIxKernelOut : output map [row][col], N = SIZE-SIZEKer+1 per side
//
// Configuration macro:
//   CONV2_SATURATE_EN : clamp results instead of wrapping (timing unchanged)
// -----------------------------------------------------------------------------
module conv_2
    import conv2_pkg::*;
#(
    parameter int SIZE      = 320,
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = 16
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic signed [WIDTH_BIT-1:0] inpMatrixI [SIZE][SIZE],
    output logic                        done,
    output logic signed [WIDTH_BIT-1:0] convIxKernelOut [SIZE-SIZEKer+1][SIZE-SIZEKer+1]
);

    localparam int N  = SIZE - SIZEKer + 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(SIZE);
    localparam int AW = acc_width(WIDTH_BIT, SIZEKer);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t                      state;
    state_t                      state_next;
    logic [CW-1:0]               row;
    logic [CW-1:0]               col;
    logic                        last;
    logic                        compute;
    logic signed [WIDTH_BIT-1:0] win [SIZEKer][SIZEKer];
    logic signed [AW-1:0]        mac_sum;
    logic signed [WIDTH_BIT-1:0] mac_result;

    // ---------------------------------------------------------------- FSM
    // IDLE is the post-reset state; the first clock out of reset already
    // computes window (0,0), so IDLE and RUN both write a pixel.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        case (state)
            IDLE, RUN: state_next = last ? DONE : RUN;
            DONE:      state_next = DONE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        compute = (state != DONE);
        last    = (row == LAST) && (col == LAST);
    end

    // ----------------------------------------------------- window counters
    // Counters hold at (N-1,N-1) after the last window so the window
    // address never leaves the image.
    always_ff @(posedge clock) begin
        if (nreset) begin
            row <= '0;
            col <= '0;
        end else if (compute && !last) begin
            if (col == LAST) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // ------------------------------------------------------ window select
    always_comb begin
        for (int i = 0; i < SIZEKer; i++) begin
            for (int j = 0; j < SIZEKer; j++) begin
                win[i][j] = inpMatrixI[IW'(row) + IW'(i)][IW'(col) + IW'(j)];
            end
        end
    end

    conv2_window_mac #(
        .SIZEKer   (SIZEKer),
        .WIDTH_BIT (WIDTH_BIT),
        .AW        (AW)
    ) u_mac (
        .win    (win),
        .sum    (mac_sum),
        .result (mac_result)
    );

    // ------------------------------------------------------- output array
    always_ff @(posedge clock) begin
        if (nreset) begin
            // NOTE: this register array is cleared on reset on purpose:
            // cells not yet computed must read as 0. Plain storage arrays
            // normally are not reset.
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    convIxKernelOut[r][c] <= '0;
                end
            end
        end else if (compute) begin
            convIxKernelOut[row][col] <= mac_result;
        end
    end

    // done follows DONE by one clock: it rises the edge after the last write.
    always_ff @(posedge clock) begin
        if (nreset) begin
            done <= 1'b0;
        end else if (state == DONE) begin
            done <= 1'b1;
        end
    end

    // The stored result must be the wrapped or clamped form of the full sum.
    always_ff @(posedge clock) begin
        if (!nreset && compute) begin
`ifdef CONV2_SATURATE_EN
            assert (mac_result == WIDTH_BIT'(sat(64'(mac_sum), WIDTH_BIT)));
`else
            assert (mac_result == mac_sum[WIDTH_BIT-1:0]);
`endif
        end
    end

endmodule

// File: tb/tb_conv_2.sv
// -----------------------------------------------------------------------------
// tb_conv_2
// Directed bench for conv_2: three instances (SIZE 8, 6 and 3, kernel 3,
// 16-bit pixels) share one clock and have independent resets. Each scenario
// task drives an image, releases reset and compares outputs against
// hand-derived values.
// -----------------------------------------------------------------------------
module tb_conv_2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst8 = 1'b1;
    logic rst6 = 1'b1;
    logic rst3 = 1'b1;

    logic signed [15:0] img8 [8][8];
    logic signed [15:0] img6 [6][6];
    logic signed [15:0] img3 [3][3];

    logic signed [15:0] out8 [6][6];
    logic signed [15:0] out6 [4][4];
    logic signed [15:0] out3 [1][1];

    logic done8;
    logic done6;
    logic done3;

    int checks   = 0;
    int failures = 0;

    conv_2 #(.SIZE(8), .SIZEKer(3), .WIDTH_BIT(16)) dut8 (
        .clock(clock), .nreset(rst8), .inpMatrixI(img8),
        .done(done8), .convIxKernelOut(out8)
    );

    conv_2 #(.SIZE(6), .SIZEKer(3), .WIDTH_BIT(16)) dut6 (
        .clock(clock), .nreset(rst6), .inpMatrixI(img6),
        .done(done6), .convIxKernelOut(out6)
    );

    conv_2 #(.SIZE(3), .SIZEKer(3), .WIDTH_BIT(16)) dut3 (
        .clock(clock), .nreset(rst3), .inpMatrixI(img3),
        .done(done3), .convIxKernelOut(out3)
    );

    // ------------------------------------------------------------ helpers
    // Reset is applied for exactly one rising edge, then released at the
    // next falling edge so the following rising edge is cycle 1.
    task automatic pulse_reset8();
        @(negedge clock); rst8 = 1'b1;
        @(negedge clock); rst8 = 1'b0;
    endtask

    task automatic pulse_reset6();
        @(negedge clock); rst6 = 1'b1;
        @(negedge clock); rst6 = 1'b0;
    endtask

    // Returns the cycle index at which done was first seen high, 0 on timeout.
    task automatic wait_done8(input int limit, output int edges);
        edges = 0;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clock); #1;
            if (done8) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic wait_done6(input int limit, output int edges);
        edges = 0;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clock); #1;
            if (done6) begin
                edges = k;
                break;
            end
        end
    endtask

    // ------------------------------------------------------------ scenarios
    task automatic test_reset();
        int nz;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img8[r][c] = 16'sd7;
        @(negedge clock); rst8 = 1'b1;
        @(negedge clock);
        nz = 0;
        for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) if (out8[r][c] !== 16'sd0) nz++;
        checks++;
        if (done8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %b expected 0", done8);
        end
        checks++;
        if (nz !== 0) begin
            failures++;
            $display("FAIL reset_cells: %0d nonzero cells, expected 0", nz);
        end
    endtask

    task automatic test_uniform();
        int edges;
        int nz;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img8[r][c] = 16'sh0005;
        pulse_reset8();
        wait_done8(100, edges);
        checks++;
        if (edges !== 37) begin
            failures++;
            $display("FAIL uniform_done_latency: done at cycle %0d, expected 37", edges);
        end
        nz = 0;
        for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) if (out8[r][c] !== 16'sd0) nz++;
        checks++;
        if (nz !== 0) begin
            failures++;
            $display("FAIL uniform_cells: %0d nonzero cells, expected 0", nz);
        end
    endtask

    task automatic test_impulse();
        int edges;
        logic signed [15:0] exp_v;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img8[r][c] = 16'sd0;
        img8[4][4] = 16'sh0001;
        pulse_reset8();
        // Cell (3,3) is registered at cycle 3*6+3+1 = 22; (3,2) at 21.
        repeat (21) @(posedge clock);
        #1;
        checks++;
        if (out8[3][2] !== -16'sd1) begin
            failures++;
            $display("FAIL impulse_cell_3_2_at_21: got %0d expected -1", out8[3][2]);
        end
        checks++;
        if (out8[3][3] !== 16'sd0) begin
            failures++;
            $display("FAIL impulse_pending_3_3: got %0d expected 0", out8[3][3]);
        end
        @(posedge clock); #1;
        checks++;
        if (out8[3][3] !== 16'sd8) begin
            failures++;
            $display("FAIL impulse_cell_3_3_at_22: got %0d expected 8", out8[3][3]);
        end
        wait_done8(100, edges);
        checks++;
        if (edges + 22 !== 37) begin
            failures++;
            $display("FAIL impulse_done_latency: done at cycle %0d, expected 37", edges + 22);
        end
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                if (r == 3 && c == 3)                         exp_v = 16'sd8;
                else if (r >= 2 && r <= 4 && c >= 2 && c <= 4) exp_v = -16'sd1;
                else                                          exp_v = 16'sd0;
                checks++;
                if (out8[r][c] !== exp_v) begin
                    failures++;
                    $display("FAIL impulse_map[%0d][%0d]: got %0d expected %0d", r, c, out8[r][c], exp_v);
                end
            end
        end
    endtask

    task automatic test_ramp();
        int edges;
        for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) img6[r][c] = 16'(r * 6 + c);
        pulse_reset6();
        wait_done6(100, edges);
        checks++;
        if (edges !== 17) begin
            failures++;
            $display("FAIL ramp_done_latency: done at cycle %0d, expected 17", edges);
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (out6[r][c] !== 16'sd0) begin
                    failures++;
                    $display("FAIL ramp_map[%0d][%0d]: got %0d expected 0", r, c, out6[r][c]);
                end
            end
        end
    endtask

    // Impulse at (1,1): out[0][0]=8, out[0][1]=out[1][0]=out[1][1]=-1.
    task automatic test_abort_restart();
        int edges;
        logic signed [15:0] exp_v;
        for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) img6[r][c] = 16'sd0;
        img6[1][1] = 16'sh0001;
        pulse_reset6();
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (out6[0][0] !== 16'sd8 || out6[0][1] !== -16'sd1) begin
            failures++;
            $display("FAIL abort_partial: got (%0d,%0d) expected (8,-1)", out6[0][0], out6[0][1]);
        end
        checks++;
        if (out6[1][0] !== 16'sd0) begin
            failures++;
            $display("FAIL abort_pending_1_0: got %0d expected 0", out6[1][0]);
        end
        @(negedge clock); rst6 = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (out6[0][0] !== 16'sd0 || out6[0][1] !== -16'sd0 || done6 !== 1'b0) begin
            failures++;
            $display("FAIL abort_cleared: got (%0d,%0d,done=%b) expected (0,0,done=0)",
                     out6[0][0], out6[0][1], done6);
        end
        @(negedge clock); rst6 = 1'b0;
        wait_done6(100, edges);
        checks++;
        if (edges !== 17) begin
            failures++;
            $display("FAIL restart_done_latency: done at cycle %0d, expected 17", edges);
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r == 0 && c == 0)      exp_v = 16'sd8;
                else if (r <= 1 && c <= 1) exp_v = -16'sd1;
                else                       exp_v = 16'sd0;
                checks++;
                if (out6[r][c] !== exp_v) begin
                    failures++;
                    $display("FAIL restart_map[%0d][%0d]: got %0d expected %0d", r, c, out6[r][c], exp_v);
                end
            end
        end
    endtask

    // Centre 0x7FFF, neighbours 0x8000: true sum 524280 = 0x7FFF8.
    task automatic test_overflow();
        logic signed [15:0] exp_v;
`ifdef CONV2_SATURATE_EN
        exp_v = 16'sh7FFF;
`else
        exp_v = 16'shFFF8;
`endif
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) img3[r][c] = 16'sh8000;
        img3[1][1] = 16'sh7FFF;
        @(negedge clock); rst3 = 1'b1;
        @(negedge clock); rst3 = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (out3[0][0] !== exp_v) begin
            failures++;
            $display("FAIL overflow_value: got 0x%04h expected 0x%04h", out3[0][0], exp_v);
        end
        checks++;
        if (done3 !== 1'b0) begin
            failures++;
            $display("FAIL overflow_done_early: got %b expected 0 at cycle 1", done3);
        end
        @(posedge clock); #1;
        checks++;
        if (done3 !== 1'b1) begin
            failures++;
            $display("FAIL overflow_done_cycle2: got %b expected 1", done3);
        end
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (done3 !== 1'b1 || out3[0][0] !== exp_v) begin
            failures++;
            $display("FAIL done_sticky: got done=%b value=0x%04h expected done=1 value=0x%04h",
                     done3, out3[0][0], exp_v);
        end
    endtask

    initial begin
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img8[r][c] = 16'sd0;
        for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) img6[r][c] = 16'sd0;
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) img3[r][c] = 16'sd0;
        test_reset();
        test_uniform();
        test_impulse();
        test_ramp();
        test_abort_restart();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
